// File: rtl/adsr_envelope.sv
// ADSR envelope generator: tick-paced attack/decay/sustain/release
// level with gate retrigger and saturating arithmetic.
module adsr_envelope #(
  parameter int TICK_DIV = 5000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ENV_PARAMS,
  input  logic        GATE,
  output logic [15:0] ENV_OUT,
  output logic [2:0]  ENV_STATE,
  output logic        ENV_ACTIVE
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  env_state_t    state, state_n;
  logic [15:0]   level, level_n;
  logic [CW-1:0] cnt;
  logic          gate_d;
  logic          tick, rise, fall;
  logic [16:0]   step_a, step_d, step_r;
  logic [16:0]   atk_sum;
  logic [15:0]   sus, dec_gap;

  assign tick = (cnt == CNT_MAX);
  assign rise = GATE & ~gate_d;
  assign fall = ~GATE & gate_d;

  assign step_a  = {9'd0, ENV_PARAMS[31:24]} + 17'd1;
  assign step_d  = {9'd0, ENV_PARAMS[23:16]} + 17'd1;
  assign step_r  = {9'd0, ENV_PARAMS[7:0]} + 17'd1;
  assign sus     = {ENV_PARAMS[15:8], ENV_PARAMS[15:8]};
  assign atk_sum = {1'b0, level} + step_a;
  assign dec_gap = level - sus;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      level  <= '0;
      cnt    <= '0;
      gate_d <= 1'b0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      cnt    <= tick ? '0 : cnt + 1'b1;
      gate_d <= GATE;
    end
  end

  // Gate edges win over a coincident tick and freeze the level.
  always_comb begin
    state_n = state;
    level_n = level;
    if (rise) begin
      state_n = ATTACK;
    end else if (fall && (state == ATTACK || state == DECAY ||
                          state == SUSTAIN)) begin
      state_n = RELEASE;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          level_n = '0;
        end
        ATTACK: begin
          if (atk_sum >= 17'h0FFFF) begin
            level_n = 16'hFFFF;
            state_n = DECAY;
          end else begin
            level_n = atk_sum[15:0];
          end
        end
        DECAY: begin
          if (level > sus && {1'b0, dec_gap} > step_d) begin
            level_n = level - step_d[15:0];
          end else begin
            level_n = sus;
            state_n = SUSTAIN;
          end
        end
        SUSTAIN: begin
          level_n = sus;
        end
        RELEASE: begin
          if ({1'b0, level} <= step_r) begin
            level_n = '0;
            state_n = IDLE;
          end else begin
            level_n = level - step_r[15:0];
          end
        end
        default: begin
          level_n = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  assign ENV_OUT    = level;
  assign ENV_STATE  = state;
  assign ENV_ACTIVE = (state != IDLE);

endmodule
